// File: rtl/loopback_msg_arbiter.sv
// Round-robin arbiter that merges REQ_COUNT AXI-Stream message sources onto one loopback stream, prefixing each frame with a tag/index header.
// Optional per-requester frame counters are enabled by defining LOOPBACK_ARB_STATS_EN.
module loopback_msg_arbiter #(
  parameter int DATA_WIDTH    = 64,
  parameter int STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int REQ_COUNT     = 4,
  parameter int ID_TAG_WIDTH  = 9,
  parameter int REQ_SEL_WIDTH = $clog2(REQ_COUNT)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [REQ_COUNT*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [REQ_COUNT*STRB_WIDTH-1:0]   s_axis_tkeep,
  input  logic [REQ_COUNT-1:0]              s_axis_tvalid,
  input  logic [REQ_COUNT-1:0]              s_axis_tlast,
  output logic [REQ_COUNT-1:0]              s_axis_tready,
  input  logic [REQ_COUNT*ID_TAG_WIDTH-1:0] s_axis_tdest,
  output logic [DATA_WIDTH-1:0]             m_axis_tdata,
  output logic [STRB_WIDTH-1:0]             m_axis_tkeep,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  output logic [REQ_SEL_WIDTH-1:0]          grant_idx,
  output logic                              busy,
  output logic [REQ_COUNT*32-1:0]           frame_count
);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t                    state;
  logic [REQ_SEL_WIDTH-1:0]  grant_q;
  logic [ID_TAG_WIDTH-1:0]   dest_q;
  logic [REQ_SEL_WIDTH-1:0]  rr_pick;
  logic                      rr_found;
  logic [DATA_WIDTH-1:0]     hdr_data;
  logic                      frame_done;

  // Search starts one past the last grant so every valid requester is served within REQ_COUNT frames.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    rr_pick  = grant_q;
    rr_found = 1'b0;
    for (int k = 1; k <= REQ_COUNT; k++) begin
      if (!rr_found && s_axis_tvalid[(int'(grant_q) + k) % REQ_COUNT]) begin
        rr_pick  = REQ_SEL_WIDTH'((int'(grant_q) + k) % REQ_COUNT);
        rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    hdr_data                                   = '0;
    hdr_data[ID_TAG_WIDTH-1:0]                 = dest_q;
    hdr_data[ID_TAG_WIDTH +: REQ_SEL_WIDTH]    = grant_q;
  end

  // Header comes from registers; payload beats pass straight through from the granted source.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    case (state)
      HDR: begin
        m_axis_tdata  = hdr_data;
        m_axis_tkeep  = '1;
        m_axis_tvalid = 1'b1;
      end
      DATA: begin
        m_axis_tdata             = s_axis_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
        m_axis_tkeep             = s_axis_tkeep[int'(grant_q)*STRB_WIDTH +: STRB_WIDTH];
        m_axis_tvalid            = s_axis_tvalid[grant_q];
        m_axis_tlast             = s_axis_tlast[grant_q];
        s_axis_tready[grant_q]   = m_axis_tready;
      end
      default: ;
    endcase
  end

  assign frame_done = (state == DATA) && m_axis_tvalid && m_axis_tready && m_axis_tlast;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!rst_n) begin
      state   <= IDLE;
      grant_q <= REQ_SEL_WIDTH'(REQ_COUNT - 1);
      dest_q  <= '0;
    end else begin
      case (state)
        IDLE: if (rr_found) begin
          grant_q <= rr_pick;
          dest_q  <= s_axis_tdest[int'(rr_pick)*ID_TAG_WIDTH +: ID_TAG_WIDTH];
          state   <= HDR;
        end
        HDR:     if (m_axis_tready) state <= DATA;
        DATA:    if (frame_done)    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign grant_idx = grant_q;
  assign busy      = (state != IDLE);

`ifdef LOOPBACK_ARB_STATS_EN
  logic [31:0] frame_cnt [REQ_COUNT];

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: this is a small flop array, not a RAM, so each counter can be cleared by reset.
    if (!rst_n) begin
      for (int i = 0; i < REQ_COUNT; i++) frame_cnt[i] <= '0;
    end else if (frame_done) begin
      frame_cnt[grant_q] <= frame_cnt[grant_q] + 32'd1;
    end
  end

  always_comb begin
    frame_count = '0;
    for (int i = 0; i < REQ_COUNT; i++) frame_count[i*32 +: 32] = frame_cnt[i];
  end
`else
  assign frame_count = '0;
`endif

endmodule

// File: tb/tb_loopback_msg_arbiter.sv
// Directed bench for loopback_msg_arbiter: per-requester source queues, a scoreboard of expected output beats,
// and immediate-assertion checks. Frame-counter expectations follow LOOPBACK_ARB_STATS_EN.
module tb_loopback_msg_arbiter;
  localparam int DW = 64;
  localparam int SW = 8;
  localparam int RC = 4;
  localparam int TW = 9;
  localparam int GW = 2;

  typedef struct {
    logic [DW-1:0] data;
    logic [SW-1:0] keep;
    logic          last;
    logic [TW-1:0] dest;
  } src_beat_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [SW-1:0] keep;
    logic          last;
    int            src;
  } exp_beat_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [RC*DW-1:0]  s_tdata = '0;
  logic [RC*SW-1:0]  s_tkeep = '0;
  logic [RC-1:0]     s_tvalid = '0;
  logic [RC-1:0]     s_tlast = '0;
  logic [RC-1:0]     s_tready;
  logic [RC*TW-1:0]  s_tdest = '0;
  logic [DW-1:0]     m_tdata;
  logic [SW-1:0]     m_tkeep;
  logic              m_tvalid;
  logic              m_tlast;
  logic              m_tready = 1'b1;
  logic [GW-1:0]     grant_idx;
  logic              busy;
  logic [RC*32-1:0]  frame_count;

  src_beat_t         src_q [RC][$];
  exp_beat_t         exp_q [$];
  logic [RC-1:0]     stall = '0;
  logic [RC-1:0]     pop_pend = '0;
  logic [TW-1:0]     dest_xor [RC];
  int                exp_cnt [RC];
  int                n_checks = 0;
  int                n_errors = 0;
  int                fr_id = 0;

  loopback_msg_arbiter #(
    .DATA_WIDTH(DW), .STRB_WIDTH(SW), .REQ_COUNT(RC), .ID_TAG_WIDTH(TW), .REQ_SEL_WIDTH(GW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tready(s_tready), .s_axis_tdest(s_tdest),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
    .grant_idx(grant_idx), .busy(busy), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queue one frame at a requester; the header plus the first nexp data beats are expected at the output.
  task automatic push_frame(input int req, input int nb, input logic [TW-1:0] dest, input int nexp);
    exp_beat_t e;
    src_beat_t s;
    e.data = 64'(dest) | (64'(req) << TW);
    e.keep = '1;
    e.last = 1'b0;
    e.src  = -1;
    exp_q.push_back(e);
    for (int b = 0; b < nb; b++) begin
      s.data = {8'(req), 8'(fr_id), 40'h0, 8'(b)};
      s.keep = (b == nb - 1) ? 8'h0F : 8'hFF;
      s.last = (b == nb - 1);
      s.dest = dest;
      src_q[req].push_back(s);
      if (b < nexp) begin
        e.data = s.data;
        e.keep = s.keep;
        e.last = s.last;
        e.src  = req;
        exp_q.push_back(e);
      end
    end
    fr_id++;
  endtask

  task automatic check_stats(input string tag);
    int expv;
    for (int i = 0; i < RC; i++) begin
`ifdef LOOPBACK_ARB_STATS_EN
      expv = exp_cnt[i];
`else
      expv = 0;
`endif
      check($sformatf("%s_cnt%0d", tag, i), 128'(frame_count[i*32 +: 32]), 128'(expv));
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < RC; i++) begin
      src_q[i].delete();
      exp_cnt[i] = 0;
    end
    exp_q.delete();
    pop_pend = '0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk); #4;
      n++;
    end
    check({tag, "_drain"}, 128'(exp_q.size()), 128'(0));
    @(negedge clk); #4;
  endtask

  // Source drivers update just after the falling edge; the monitor samples just before the rising edge.
  always begin
    @(negedge clk); #1;
    for (int i = 0; i < RC; i++) begin
      if (pop_pend[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      pop_pend[i] = 1'b0;
      if (src_q[i].size() > 0 && !stall[i]) begin
        s_tvalid[i]          = 1'b1;
        s_tdata[i*DW +: DW]  = src_q[i][0].data;
        s_tkeep[i*SW +: SW]  = src_q[i][0].keep;
        s_tlast[i]           = src_q[i][0].last;
      end else begin
        s_tvalid[i]          = 1'b0;
        s_tdata[i*DW +: DW]  = '0;
        s_tkeep[i*SW +: SW]  = '0;
        s_tlast[i]           = 1'b0;
      end
      s_tdest[i*TW +: TW] = ((src_q[i].size() > 0) ? src_q[i][0].dest : '0) ^ dest_xor[i];
    end
    #2;
    if (rst_n) begin
      for (int i = 0; i < RC; i++)
        if (s_tvalid[i] && s_tready[i]) pop_pend[i] = 1'b1;
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check("out_unexpected", 128'(exp_q.size()), 128'(1));
        end else begin
          exp_beat_t e;
          e = exp_q.pop_front();
          check("out_beat", {55'h0, m_tdata, m_tkeep, m_tlast}, {55'h0, e.data, e.keep, e.last});
          if (e.last && e.src >= 0) exp_cnt[e.src]++;
        end
      end
    end
  end

  initial begin
    int n;
    for (int i = 0; i < RC; i++) dest_xor[i] = '0;
    clear_model();

    // Reset state
    repeat (2) @(negedge clk);
    #4;
    check("rst_mvalid", 128'(m_tvalid), 128'(0));
    check("rst_busy",   128'(busy),     128'(0));
    check("rst_sready", 128'(s_tready), 128'(0));
    check_stats("rst");
    @(negedge clk); rst_n = 1'b1;

    // Two requesters, 3-beat frames: requester 0 first, then 2
    @(negedge clk);
    push_frame(0, 3, 9'h011, 3);
    push_frame(2, 3, 9'h022, 3);
    #4;
    check("t1_latency_idle", 128'(m_tvalid), 128'(0));
    @(negedge clk); #4;
    check("t1_hdr_valid", 128'(m_tvalid), 128'(1));
    check("t1_hdr_data",  128'(m_tdata),  128'(64'h011));
    check("t1_hdr_keep",  128'(m_tkeep),  128'(8'hFF));
    check("t1_hdr_sready", 128'(s_tready), 128'(0));
    check("t1_grant", 128'(grant_idx), 128'(0));
    drain("t1");
    check_stats("t1");

    // All four continuously valid with 1-beat frames: 3 cycles per frame, grant order 0,1,2,3,...
    @(negedge clk); rst_n = 1'b0; clear_model();
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < RC; r++) push_frame(r, 1, 9'(9'h100 + r), 1);
    #4;
    check("t2_idle_first", 128'(busy), 128'(0));
    n = 0;
    do begin @(negedge clk); #4; n++; end while (!busy && n < 20);
    check("t2_start", 128'(busy), 128'(1));
    for (int k = 0; k < 2 * RC * 3; k++) begin
      if (k > 0) begin @(negedge clk); #4; end
      check($sformatf("t2_cyc%0d", k), {busy, grant_idx}, {(k % 3) != 2, GW'((k / 3) % RC)});
    end
    drain("t2");
    check_stats("t2");

    // Header held while m_axis_tready is low; late tdest change must not alter it
    @(negedge clk);
    m_tready = 1'b0;
    push_frame(1, 2, 9'h0AB, 2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 1) dest_xor[1] = 9'h1FF;
      #4;
      check($sformatf("t3_hold_valid%0d", k),  128'(m_tvalid), 128'(1));
      check($sformatf("t3_hold_data%0d", k),   128'(m_tdata),  128'(64'h2AB));
      check($sformatf("t3_hold_sready%0d", k), 128'(s_tready), 128'(0));
    end
    @(negedge clk); m_tready = 1'b1;
    drain("t3");
    dest_xor[1] = '0;

    // Granted requester pauses 2 cycles mid-frame while others wait
    @(negedge clk);
    push_frame(2, 4, 9'h033, 4);
    push_frame(3, 1, 9'h044, 1);
    push_frame(0, 1, 9'h055, 1);
    @(negedge clk); #4;
    check("t4_grant", 128'(grant_idx), 128'(2));
    @(negedge clk); #4;
    @(negedge clk); stall[2] = 1'b1; #4;
    check("t4_gap1_valid", 128'(m_tvalid), 128'(0));
    check("t4_gap1_sready", 128'(s_tready), 128'(4'b0100));
    @(negedge clk); #4;
    check("t4_gap2_valid", 128'(m_tvalid), 128'(0));
    check("t4_gap2_state", {busy, grant_idx}, {1'b1, 2'd2});
    @(negedge clk); stall[2] = 1'b0; #4;
    check("t4_resume", {m_tvalid, grant_idx}, {1'b1, 2'd2});
    drain("t4");
    check_stats("t4");

    // Reset mid-frame after 2 of 4 beats, then requester 0 must win first
    @(negedge clk);
    push_frame(1, 4, 9'h066, 2);
    repeat (3) begin @(negedge clk); #4; end
    @(negedge clk);
    rst_n = 1'b0;
    check("t5_consumed", 128'(exp_q.size()), 128'(0));
    clear_model();
    #4;
    check("t5_rst_valid",  128'(m_tvalid), 128'(0));
    check("t5_rst_busy",   128'(busy),     128'(0));
    check("t5_rst_sready", 128'(s_tready), 128'(0));
    check_stats("t5_rst");
    @(negedge clk);
    rst_n = 1'b1;
    push_frame(0, 1, 9'h088, 1);
    push_frame(1, 1, 9'h077, 1);
    @(negedge clk); #4;
    check("t5_first_grant", {m_tvalid, grant_idx}, {1'b1, 2'd0});
    drain("t5");
    check_stats("t5");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
